// File: rtl/census_pkg.sv
// Shared constants and FSM state encoding for the census line-buffer sequencer.
package census_pkg;

   localparam int WIN     = 5;
   localparam int AWIDTH  = 11;
   localparam int MIN_DIM = WIN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/census_pos_counter.sv
// Column/row raster position counter: latches frame size, advances on accepted
// pixels with column wrap into row increment, and flags the frame's last pixel.
module census_pos_counter #(
   parameter int AWIDTH = census_pkg::AWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [AWIDTH-1:0] i_width,
   input  logic [AWIDTH-1:0] i_height,
   input  logic              i_adv,
   output logic [AWIDTH-1:0] o_col,
   output logic [AWIDTH-1:0] o_row,
   output logic              o_last
);

   logic [AWIDTH-1:0] r_width;
   logic [AWIDTH-1:0] r_height;
   logic [AWIDTH-1:0] r_col;
   logic [AWIDTH-1:0] r_row;
   logic              w_col_end;
   logic              w_row_end;

   assign w_col_end = (r_col == r_width - AWIDTH'(1));
   assign w_row_end = (r_row == r_height - AWIDTH'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_width  <= '0;
         r_height <= '0;
         r_col    <= '0;
         r_row    <= '0;
      end else if (i_load) begin
         r_width  <= i_width;
         r_height <= i_height;
         r_col    <= '0;
         r_row    <= '0;
      end else if (i_adv) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= w_row_end ? '0 : r_row + AWIDTH'(1);
         end else begin
            r_col <= r_col + AWIDTH'(1);
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/census_linebuf_sequencer.sv
// Frame scheduler driving the five line-buffer row enables and the 5x5 window flag.
// Optional stall-cycle counter output enabled by defining CENSUS_STALL_CNT_EN.
module census_linebuf_sequencer #(
   parameter int AWIDTH = census_pkg::AWIDTH,
   parameter int WIN    = census_pkg::WIN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] width,
   input  logic [AWIDTH-1:0] height,
   input  logic              pix_valid,
   output logic              clken,
   output logic              en2,
   output logic              en3,
   output logic              en4,
   output logic              en5,
   output logic              window_valid,
   output logic [AWIDTH-1:0] win_col,
   output logic [AWIDTH-1:0] win_row,
   output logic              busy,
   output logic              frame_done,
   output logic              cfg_err
`ifdef CENSUS_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);
   import census_pkg::*;

   // state | meaning
   // IDLE  | waiting for a start with legal dimensions
   // RUN   | accepting pixels, driving row enables
   // DONE  | single cycle after the last pixel, frame_done high

   state_e            r_state;
   state_e            w_state_nxt;
   logic              w_acc;
   logic              w_dims_ok;
   logic              w_start_ok;
   logic [AWIDTH-1:0] w_col;
   logic [AWIDTH-1:0] w_row;
   logic              w_last;
   logic              r_window_valid;
   logic [AWIDTH-1:0] r_win_col;
   logic [AWIDTH-1:0] r_win_row;
   logic              r_busy;
   logic              r_frame_done;
   logic              r_cfg_err;

   assign w_acc      = (r_state == RUN) && pix_valid;
   assign w_dims_ok  = (width >= AWIDTH'(MIN_DIM)) && (height >= AWIDTH'(MIN_DIM));
   assign w_start_ok = (r_state == IDLE) && start && w_dims_ok;

   census_pos_counter #(.AWIDTH(AWIDTH)) u_pos (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_start_ok),
      .i_width  (width),
      .i_height (height),
      .i_adv    (w_acc),
      .o_col    (w_col),
      .o_row    (w_row),
      .o_last   (w_last)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_start_ok) w_state_nxt = RUN;
         RUN:     if (w_acc && w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= IDLE;
         r_window_valid <= 1'b0;
         r_win_col      <= '0;
         r_win_row      <= '0;
         r_busy         <= 1'b0;
         r_frame_done   <= 1'b0;
         r_cfg_err      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_busy         <= (w_state_nxt == RUN);
         r_frame_done   <= w_acc && w_last;
         r_cfg_err      <= (r_state == IDLE) && start && !w_dims_ok;
         // A window is complete once the pixel sits at or beyond the 5th row and column.
         r_window_valid <= w_acc && (w_row >= AWIDTH'(WIN-1)) && (w_col >= AWIDTH'(WIN-1));
         if (w_acc) begin
            r_win_col <= w_col;
            r_win_row <= w_row;
         end
      end
   end

   assign clken = w_acc;
   assign en2   = w_acc && (w_row >= AWIDTH'(1));
   assign en3   = w_acc && (w_row >= AWIDTH'(2));
   assign en4   = w_acc && (w_row >= AWIDTH'(3));
   assign en5   = w_acc && (w_row >= AWIDTH'(4));

   assign window_valid = r_window_valid;
   assign win_col      = r_win_col;
   assign win_row      = r_win_row;
   assign busy         = r_busy;
   assign frame_done   = r_frame_done;
   assign cfg_err      = r_cfg_err;

`ifdef CENSUS_STALL_CNT_EN
   logic [15:0] r_stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
      end else if (w_start_ok) begin
         r_stall_cnt <= '0;
      end else if ((r_state == RUN) && !pix_valid && (r_stall_cnt != 16'hFFFF)) begin
         r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
